// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV64M multiply/divide unit, one bit per cycle
//                (shift-add multiply, restoring divide) with valid/ready I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] C_LO32   = XLEN'({32{1'b1}});
    localparam logic [XLEN-1:0] C_MIN32  = XLEN'(33'h0_8000_0000);
    localparam logic [XLEN-1:0] C_MINX   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]      C_MUL    = 3'd0;
    localparam logic [2:0]      C_MULH   = 3'd1;
    localparam logic [2:0]      C_MULHSU = 3'd2;
    localparam logic [2:0]      C_MULHU  = 3'd3;
    localparam logic [2:0]      C_DIV    = 3'd4;
    localparam logic [2:0]      C_DIVU   = 3'd5;
    localparam logic [2:0]      C_REM    = 3'd6;
    localparam logic [2:0]      C_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Sign-extend bit 31 across the full width; identity when XLEN==32.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] t;
        t = v << (XLEN - 32);
        return $signed(t) >>> (XLEN - 32);
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic [2:0]        r_op;
    logic              r_word;
    logic              r_sa;
    logic              r_sb;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_prod;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_shift;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_divisor;

    // ------------------------------------------------------------------
    // Request decode: operands reduced to width N and taken to magnitudes
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_word;
    logic [XLEN-1:0] w_mask;
    logic [XLEN-1:0] w_a_n;
    logic [XLEN-1:0] w_b_n;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min_n;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_dvd_init;
    logic [CW-1:0]   w_n;

    assign in_ready   = (r_state == S_IDLE) && !reset;
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_word     = (XLEN == 64) && word;
    assign w_mask     = w_word ? C_LO32 : '1;
    assign w_a_n      = a & w_mask;
    assign w_b_n      = b & w_mask;
    assign w_a_signed = (op == C_MULH) || (op == C_MULHSU) || (op == C_DIV) || (op == C_REM);
    assign w_b_signed = (op == C_MULH) || (op == C_DIV) || (op == C_REM);
    assign w_sa       = w_a_signed && (w_word ? a[31] : a[XLEN-1]);
    assign w_sb       = w_b_signed && (w_word ? b[31] : b[XLEN-1]);
    assign w_a_mag    = w_sa ? ((-w_a_n) & w_mask) : w_a_n;
    assign w_b_mag    = w_sb ? ((-w_b_n) & w_mask) : w_b_n;
    assign w_min_n    = w_word ? C_MIN32 : C_MINX;
    assign w_b_zero   = (w_b_n == '0);
    assign w_ovf      = w_a_signed && w_b_signed && (w_a_n == w_min_n) && (w_b_n == w_mask);
    assign w_special  = op[2] && (w_b_zero || w_ovf);
    assign w_n        = w_word ? CW'(32) : CW'(XLEN);
    // Left-align a 32-bit dividend so the restoring loop always starts at the MSB.
    assign w_dvd_init = w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;

    always_comb begin
        w_special_res = '1;
        if (w_b_zero) begin
            if (op[1]) begin
                w_special_res = w_word ? sext32(a) : a;
            end
        end else begin
            w_special_res = op[1] ? '0 : (w_word ? sext32(w_min_n) : w_min_n);
        end
    end

    // ------------------------------------------------------------------
    // One iteration step, plus the sign fixup applied to the final step
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_nxt;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN:0]     w_div_cat;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_shift_nxt;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_raw;
    logic [XLEN-1:0]   w_fix_res;

    assign w_prod_nxt  = r_prod + (r_shift[0] ? r_mcand : '0);
    assign w_div_cat   = {r_rem, r_shift[XLEN-1]};
    assign w_div_ge    = (w_div_cat >= {1'b0, r_divisor});
    assign w_div_sub   = w_div_cat[XLEN-1:0] - r_divisor;
    assign w_rem_nxt   = w_div_ge ? w_div_sub : w_div_cat[XLEN-1:0];
    assign w_shift_nxt = r_op[2] ? {r_shift[XLEN-2:0], w_div_ge} : (r_shift >> 1);

    assign w_prod_fix  = (r_sa ^ r_sb) ? (-w_prod_nxt) : w_prod_nxt;
    assign w_quo_fix   = (r_sa ^ r_sb) ? (-w_shift_nxt) : w_shift_nxt;
    assign w_rem_fix   = r_sa ? (-w_rem_nxt) : w_rem_nxt;

    always_comb begin
        w_fix_raw = '0;
        case (r_op)
            C_MUL:                    w_fix_raw = w_prod_fix[XLEN-1:0];
            C_MULH, C_MULHSU, C_MULHU: w_fix_raw = r_word ? w_prod_fix[XLEN+31:32]
                                                          : w_prod_fix[2*XLEN-1:XLEN];
            C_DIV, C_DIVU:            w_fix_raw = w_quo_fix;
            C_REM, C_REMU:            w_fix_raw = w_rem_fix;
            default:                  w_fix_raw = '0;
        endcase
        w_fix_res = r_word ? sext32(w_fix_raw) : w_fix_raw;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_BUSY;
            S_BUSY: if (r_count == CW'(1)) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == S_DONE);
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result  <= '0;
            r_op      <= '0;
            r_word    <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_count   <= '0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_shift   <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
        end else if (!flush) begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op;
                        r_word    <= w_word;
                        r_sa      <= w_sa;
                        r_sb      <= w_sb;
                        r_count   <= w_n;
                        r_prod    <= '0;
                        r_rem     <= '0;
                        r_mcand   <= {{XLEN{1'b0}}, w_a_mag};
                        r_divisor <= w_b_mag;
                        r_shift   <= op[2] ? w_dvd_init : w_b_mag;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_BUSY: begin
                    r_prod  <= w_prod_nxt;
                    r_mcand <= r_mcand << 1;
                    r_rem   <= w_rem_nxt;
                    r_shift <= w_shift_nxt;
                    r_count <= r_count - CW'(1);
                    // Last step: sign fixup is applied to this step's outcome.
                    if (r_count == CW'(1)) begin
                        r_result <= w_fix_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit (XLEN=64) against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic        word = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .word      (word),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Architectural result of an M-extension instruction.
    function automatic logic [63:0] ref_model(input logic [2:0] f_op, input logic f_word,
                                              input logic [63:0] f_a, input logic [63:0] f_b);
        logic         sa, sb;
        logic [63:0]  ax, bx, q, r, res;
        logic [127:0] pa, pb, p;
        sa = (f_op == 3'd1) || (f_op == 3'd2) || (f_op == 3'd4) || (f_op == 3'd6);
        sb = (f_op == 3'd1) || (f_op == 3'd4) || (f_op == 3'd6);
        if (f_word) begin
            ax = sa ? {{32{f_a[31]}}, f_a[31:0]} : {32'd0, f_a[31:0]};
            bx = sb ? {{32{f_b[31]}}, f_b[31:0]} : {32'd0, f_b[31:0]};
        end else begin
            ax = f_a;
            bx = f_b;
        end
        pa = {sa ? {64{ax[63]}} : 64'd0, ax};
        pb = {sb ? {64{bx[63]}} : 64'd0, bx};
        p  = pa * pb;
        if (bx == 64'd0) begin
            q = '1;
            r = ax;
        end else if (sa && ax == 64'h8000_0000_0000_0000 && bx == 64'hFFFF_FFFF_FFFF_FFFF) begin
            q = ax;
            r = 64'd0;
        end else if (sa) begin
            q = $signed(ax) / $signed(bx);
            r = $signed(ax) % $signed(bx);
        end else begin
            q = ax / bx;
            r = ax % bx;
        end
        case (f_op)
            3'd0:             res = p[63:0];
            3'd1, 3'd2, 3'd3: res = f_word ? {32'd0, p[63:32]} : p[127:64];
            3'd4, 3'd5:       res = q;
            default:          res = r;
        endcase
        if (f_word) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    // Edges from acceptance to out_valid: 1 for a divide special case, else N+1.
    function automatic int ref_latency(input logic [2:0] f_op, input logic f_word,
                                       input logic [63:0] f_a, input logic [63:0] f_b);
        logic [63:0] an, bn;
        logic        zero, ovf;
        an   = f_word ? {32'd0, f_a[31:0]} : f_a;
        bn   = f_word ? {32'd0, f_b[31:0]} : f_b;
        zero = (bn == 64'd0);
        ovf  = ((f_op == 3'd4) || (f_op == 3'd6)) &&
               (f_word ? (an == 64'h8000_0000 && bn == 64'hFFFF_FFFF)
                       : (an == 64'h8000_0000_0000_0000 && bn == '1));
        return (f_op[2] && (zero || ovf)) ? 1 : (f_word ? 33 : 65);
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {$urandom, 32'h8000_0000};
            4:       return {$urandom, 32'hFFFF_FFFF};
            5:       return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issue one op, scramble inputs after acceptance, wait and consume the result.
    task automatic drive_op(input logic [2:0] t_op, input logic t_word, input logic [63:0] t_a,
                            input logic [63:0] t_b, output logic [63:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        op = t_op;
        word = t_word;
        a = t_a;
        b = t_b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7));
        word = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (result !== 64'd0) begin
            failures++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready_release: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec_t        v[11];
        logic [63:0] res;
        int          lat;
        v[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        v[1]  = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        v[2]  = '{3'd1, 1'b0, '1, '1, 64'd0, 65};
        v[3]  = '{3'd4, 1'b0, 64'd5, 64'd0, '1, 1};
        v[4]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        v[5]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
        v[6]  = '{3'd6, 1'b1, 64'h8000_0000, '1, 64'd0, 1};
        v[7]  = '{3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        v[8]  = '{3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 33};
        v[9]  = '{3'd5, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, 33};
        v[10] = '{3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 65};
        for (int i = 0; i < 11; i++) begin
            drive_op(v[i].op, v[i].word, v[i].a, v[i].b, res, lat);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("FAIL directed_result[%0d]: got %h expected %h", i, res, v[i].exp);
            end
            checks++;
            if (lat !== v[i].lat) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  r_op;
        logic        r_word;
        logic [63:0] ra, rb, exp, res;
        int          el, lat;
        for (int i = 0; i < 60; i++) begin
            r_op   = 3'($urandom_range(0, 7));
            r_word = 1'($urandom_range(0, 1));
            ra     = pick_operand();
            rb     = pick_operand();
            exp    = ref_model(r_op, r_word, ra, rb);
            el     = ref_latency(r_op, r_word, ra, rb);
            drive_op(r_op, r_word, ra, rb, res, lat);
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL random_result op=%0d w=%0d a=%h b=%h: got %h expected %h",
                         r_op, r_word, ra, rb, res, exp);
            end
            checks++;
            if (lat !== el) begin
                failures++;
                $display("FAIL random_latency op=%0d w=%0d: got %0d expected %0d",
                         r_op, r_word, lat, el);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ra, rb, exp, held;
        int          guard;
        ra  = {$urandom, $urandom};
        rb  = {$urandom, $urandom};
        exp = ref_model(3'd3, 1'b0, ra, rb);
        in_valid = 1'b1; op = 3'd3; word = 1'b0; a = ra; b = rb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        held = result;
        checks++;
        if (held !== exp) begin
            failures++;
            $display("FAIL bp_result: got %h expected %h", held, exp);
        end
        // A competing request during DONE must not be taken.
        in_valid = 1'b1; op = 3'd0; a = 64'd3; b = 64'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b result=%h expected valid=1 ready=0 result=%h",
                         i, out_valid, in_ready, result, exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_consume: got valid=%b ready=%b expected valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int          lat;
        bit          seen;
        in_valid = 1'b1; op = 3'd4; word = 1'b0; a = 64'd1000; b = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_busy: got valid=%b ready=%b expected valid=0 ready=1",
                     out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_result: got out_valid seen=%b expected 0", seen);
        end
        // Flush with a simultaneous request: the (special-case) request is dropped.
        in_valid = 1'b1; flush = 1'b1; op = 3'd4; a = 64'd5; b = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_with_request: got valid=%b ready=%b expected valid=0 ready=1",
                     out_valid, in_ready);
        end
        drive_op(3'd0, 1'b0, 64'd6, 64'd7, res, lat);
        checks++;
        if (res !== 64'd42) begin
            failures++;
            $display("FAIL flush_next_op: got %h expected %h", res, 64'd42);
        end
    endtask

    task automatic test_flush_done();
        int guard;
        in_valid = 1'b1; op = 3'd5; word = 1'b0; a = 64'd9; b = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (out_valid !== 1'b1 || result !== '1) begin
            failures++;
            $display("FAIL flush_done_result: got valid=%b result=%h expected valid=1 result=%h",
                     out_valid, result, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_done_idle: got valid=%b ready=%b expected valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        in_valid = 1'b1; op = 3'd0; word = 1'b0; a = 64'd123; b = 64'd456;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_assert: got valid=%b ready=%b result=%h expected 0 0 0",
                     out_valid, in_ready, result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release: got ready=%b valid=%b expected ready=1 valid=0",
                     in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_result: got out_valid seen=%b expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  r_op;
        logic [63:0] ra, rb, exp, res;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            r_op = 3'($urandom_range(0, 7));
            ra   = {$urandom, $urandom};
            rb   = 64'($urandom_range(1, 1000));
            exp  = ref_model(r_op, 1'b0, ra, rb);
            drive_op(r_op, 1'b0, ra, rb, res, lat);
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL b2b_result[%0d]: got %h expected %h", i, res, exp);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_flush_done();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
